// File: rtl/multicycle_core.sv
// Multi-cycle RV32I-subset core: one shared ALU, one memory port, FSM control.
// Executes lw/sw, add/sub/and/or/slt, addi/andi/ori/slti, beq and jal; halts on anything else.
module multicycle_core #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    REG_COUNT  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] pc,
    output logic                  retire,
    output logic                  halted
);
    localparam int RW = $clog2(REG_COUNT);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BEQ, S_JAL, S_HALT
    } state_t;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

    state_t                r_state, w_next, w_dec_next;
    logic [DATA_WIDTH-1:0] r_pc, r_oldpc, r_ir, r_a, r_b, r_aluout, r_mdr;
    logic [DATA_WIDTH-1:0] r_rf [REG_COUNT];

    logic [6:0]            w_opcode, w_f7;
    logic [2:0]            w_f3;
    logic [RW-1:0]         w_rs1, w_rs2, w_rd;
    logic [DATA_WIDTH-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j;
    logic [DATA_WIDTH-1:0] w_alu_a, w_alu_b, w_alu_y, w_rf_wd;
    alu_op_t               w_alu_op, w_fop;
    logic                  w_zero, w_req, w_rf_we;

    // Instruction fields and sign-extended immediates, all from IR
    assign w_opcode = r_ir[6:0];
    assign w_f3     = r_ir[14:12];
    assign w_f7     = r_ir[31:25];
    assign w_rs1    = r_ir[15 +: RW];
    assign w_rs2    = r_ir[20 +: RW];
    assign w_rd     = r_ir[7 +: RW];
    assign w_imm_i  = {{(DATA_WIDTH-12){r_ir[31]}}, r_ir[31:20]};
    assign w_imm_s  = {{(DATA_WIDTH-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    assign w_imm_b  = {{(DATA_WIDTH-12){r_ir[31]}}, r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_imm_j  = {{(DATA_WIDTH-20){r_ir[31]}}, r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

    // Decode legality and the state that follows DECODE; ALU function for R/I ops
    always_comb begin
        w_dec_next = S_HALT;
        w_fop      = ALU_ADD;
        case (w_f3)
            3'b111:  w_fop = ALU_AND;
            3'b110:  w_fop = ALU_OR;
            3'b010:  w_fop = ALU_SLT;
            default: w_fop = (w_opcode == OP_R && w_f7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
        endcase
        case (w_opcode)
            OP_LW, OP_SW: if (w_f3 == 3'b010) w_dec_next = S_MEMADR;
            OP_R: begin
                if ((w_f7 == 7'b0000000 && (w_f3 == 3'b000 || w_f3 == 3'b111 ||
                                            w_f3 == 3'b110 || w_f3 == 3'b010)) ||
                    (w_f7 == 7'b0100000 && w_f3 == 3'b000))
                    w_dec_next = S_EXEC_R;
            end
            OP_I: begin
                if (w_f3 == 3'b000 || w_f3 == 3'b111 || w_f3 == 3'b110 || w_f3 == 3'b010)
                    w_dec_next = S_EXEC_I;
            end
            OP_BR:   if (w_f3 == 3'b000) w_dec_next = S_BEQ;
            OP_JAL:  w_dec_next = S_JAL;
            default: w_dec_next = S_HALT;
        endcase
    end

    // Shared ALU operand selection by state
    always_comb begin
        w_alu_a  = r_a;
        w_alu_b  = r_b;
        w_alu_op = ALU_ADD;
        case (r_state)
            S_FETCH:  begin w_alu_a = r_pc;    w_alu_b = DATA_WIDTH'(4); end
            S_DECODE: begin w_alu_a = r_oldpc; w_alu_b = w_imm_b; end
            S_MEMADR: w_alu_b = (w_opcode == OP_SW) ? w_imm_s : w_imm_i;
            S_EXEC_R: w_alu_op = w_fop;
            S_EXEC_I: begin w_alu_b = w_imm_i; w_alu_op = w_fop; end
            S_BEQ:    w_alu_op = ALU_SUB;
            S_JAL:    begin w_alu_a = r_oldpc; w_alu_b = w_imm_j; end
            default:  ;
        endcase
    end

    // ALU: modulo arithmetic, signed set-less-than
    always_comb begin
        w_alu_y = w_alu_a + w_alu_b;
        case (w_alu_op)
            ALU_SUB: w_alu_y = w_alu_a - w_alu_b;
            ALU_AND: w_alu_y = w_alu_a & w_alu_b;
            ALU_OR:  w_alu_y = w_alu_a | w_alu_b;
            ALU_SLT: w_alu_y = {{(DATA_WIDTH-1){1'b0}}, $signed(w_alu_a) < $signed(w_alu_b)};
            default: ;
        endcase
    end
    assign w_zero = (w_alu_y == '0);

    // Next state, bus control, retirement and register-write selection
    always_comb begin
        w_next   = r_state;
        w_req    = 1'b0;
        mem_we   = 1'b0;
        mem_addr = {r_aluout[DATA_WIDTH-1:2], 2'b00};
        retire   = 1'b0;
        w_rf_we  = 1'b0;
        w_rf_wd  = r_aluout;
        case (r_state)
            S_FETCH: begin
                w_req    = 1'b1;
                mem_addr = {r_pc[DATA_WIDTH-1:2], 2'b00};
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE:   w_next = w_dec_next;
            S_MEMADR:   w_next = (w_opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                w_req = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB:    begin w_rf_we = 1'b1; w_rf_wd = r_mdr; retire = 1'b1; w_next = S_FETCH; end
            S_MEMWRITE: begin
                w_req  = 1'b1;
                mem_we = 1'b1;
                if (mem_ready) begin retire = 1'b1; w_next = S_FETCH; end
            end
            S_EXEC_R, S_EXEC_I: w_next = S_ALUWB;
            S_ALUWB:    begin w_rf_we = 1'b1; retire = 1'b1; w_next = S_FETCH; end
            S_BEQ:      begin retire = 1'b1; w_next = S_FETCH; end
            S_JAL:      begin w_rf_we = 1'b1; w_rf_wd = r_pc; retire = 1'b1; w_next = S_FETCH; end
            default:    w_next = S_HALT;
        endcase
    end

    // A held reset must not leave a FETCH request visible on the bus
    assign mem_req   = w_req & rst;
    assign mem_wdata = r_b;
    assign pc        = r_pc;
    assign halted    = (r_state == S_HALT);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_FETCH;
        else      r_state <= w_next;
    end

    // Datapath registers, loaded only in the state that owns them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc     <= RESET_PC;
            r_oldpc  <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            r_mdr    <= '0;
        end else begin
            case (r_state)
                S_FETCH: if (mem_ready) begin
                    r_ir    <= mem_rdata;
                    r_oldpc <= r_pc;
                    r_pc    <= w_alu_y;
                end
                S_DECODE: begin
                    r_a      <= r_rf[w_rs1];
                    r_b      <= r_rf[w_rs2];
                    r_aluout <= w_alu_y;
                end
                S_MEMADR, S_EXEC_R, S_EXEC_I: r_aluout <= w_alu_y;
                S_MEMREAD: if (mem_ready) r_mdr <= mem_rdata;
                S_BEQ:     if (w_zero) r_pc <= r_aluout;
                S_JAL:     r_pc <= w_alu_y;
                default:   ;
            endcase
        end
    end

    // Register file; x0 is never written so it always reads zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) r_rf[i] <= '0;
        end else if (w_rf_we && w_rd != '0) begin
            r_rf[w_rd] <= w_rf_wd;
        end
    end
endmodule

// File: tb/tb_multicycle_core.sv
// Self-checking bench for multicycle_core: directed vector table, multi-cycle
// corner sequences and random programs checked against an instruction-level model.
module tb_multicycle_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

    int nvec = 0;
    int nfail = 0;
    int cyc = 0;
    int nret = 0;

    logic [31:0] img [0:255];
    logic [31:0] mem [0:255];
    int          lat_cfg = 0;
    int          cur_lat = 0;
    int          wcnt = 0;
    bit          rand_lat = 1'b0;
    bit          force_rdy = 1'b0;

    multicycle_core #(.DATA_WIDTH(32), .REG_COUNT(32), .RESET_PC(32'h100)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
        .retire(retire), .halted(halted));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!rst) nret <= 0;
        else if (retire) nret <= nret + 1;
    end

    // Memory model: image copied in under reset, programmable wait states
    assign mem_rdata = mem[mem_addr[9:2]];
    assign mem_ready = force_rdy ? 1'b1 : (mem_req && wcnt >= cur_lat);
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
            wcnt    <= 0;
            cur_lat <= lat_cfg;
        end else if (mem_req && mem_ready) begin
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
            wcnt    <= 0;
            cur_lat <= rand_lat ? int'($urandom_range(0, 3)) : lat_cfg;
        end else if (mem_req) begin
            wcnt <= wcnt + 1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Encoders
    function automatic logic [31:0] r_t(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] i_t(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
        logic [31:0] im;
        im = imm;
        return {im[11:0], 5'(rs1), f3, 5'(rd), op};
    endfunction
    function automatic logic [31:0] s_t(input int imm, input int rs2, input int rs1);
        logic [31:0] im;
        im = imm;
        return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] b_t(input int imm, input int rs2, input int rs1);
        logic [31:0] im;
        im = imm;
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'b000, im[4:1], im[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] j_t(input int imm, input int rd);
        logic [31:0] im;
        im = imm;
        return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'b1101111};
    endfunction
    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return i_t(imm, rs1, 3'b000, rd, 7'b0010011);
    endfunction

    task automatic clr_img();
        for (int i = 0; i < 256; i++) img[i] = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_retire(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (retire) begin ok = 1'b1; break; end
        end
        nvec++;
        if (!ok) begin
            nfail++;
            $display("FAIL %s: got no retire within 200 cycles, required a retire pulse", nm);
        end
    endtask

    task automatic wait_halt(input string nm);
        for (int i = 0; i < 3000 && !halted; i++) @(negedge clk);
        chk(nm, {31'b0, halted}, 32'd1);
    endtask

    // beq at 0x20 after a prelude that sets x1=7, x2=9 and jumps there
    task automatic run_beq(input string nm, input logic [31:0] w, input logic [31:0] nxt);
        int t0;
        clr_img();
        img[64] = addi(1, 0, 7);
        img[65] = addi(2, 0, 9);
        img[66] = j_t(32'h20 - 32'h108, 0);
        img[8]  = w;
        do_reset();
        repeat (3) wait_retire({nm, " prelude"});
        @(negedge clk);
        t0 = cyc;
        chk({nm, " fetch addr"}, mem_addr, 32'h20);
        wait_retire(nm);
        chk({nm, " cycles"}, cyc - t0, 32'd2);
        @(negedge clk);
        chk({nm, " next fetch"}, mem_addr, nxt);
        chk({nm, " next pc"}, pc, nxt);
        chk({nm, " next req"}, {31'b0, mem_req}, 32'd1);
    endtask

    typedef struct {
        logic [31:0] instr;
        int          rd;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int kind;  // 0 addi 1 andi 2 ori 3 slti 4 add 5 sub 6 and 7 or 8 slt 9 sw 10 lw
        int rd;
        int rs1;
        int rs2;
        int imm;
    } rins_t;

    function automatic logic [31:0] enc(input rins_t p);
        case (p.kind)
            0:  return i_t(p.imm, p.rs1, 3'b000, p.rd, 7'b0010011);
            1:  return i_t(p.imm, p.rs1, 3'b111, p.rd, 7'b0010011);
            2:  return i_t(p.imm, p.rs1, 3'b110, p.rd, 7'b0010011);
            3:  return i_t(p.imm, p.rs1, 3'b010, p.rd, 7'b0010011);
            4:  return r_t(7'b0000000, p.rs2, p.rs1, 3'b000, p.rd);
            5:  return r_t(7'b0100000, p.rs2, p.rs1, 3'b000, p.rd);
            6:  return r_t(7'b0000000, p.rs2, p.rs1, 3'b111, p.rd);
            7:  return r_t(7'b0000000, p.rs2, p.rs1, 3'b110, p.rd);
            8:  return r_t(7'b0000000, p.rs2, p.rs1, 3'b010, p.rd);
            9:  return s_t(p.imm, p.rs2, 0);
            default: return i_t(p.imm, 0, 3'b010, p.rd, 7'b0000011);
        endcase
    endfunction

    vec_t  tbl [14];
    rins_t prog [12];
    logic [31:0] mr [8];
    logic [31:0] md [16];

    initial begin
        int t0, tprev, nw, nr0;
        bit found;
        logic [31:0] a, b, res;

        tbl[0]  = '{addi(1, 0, 5),                            1,  32'h00000005};
        tbl[1]  = '{addi(2, 0, -3),                           2,  32'hFFFFFFFD};
        tbl[2]  = '{r_t(7'h00, 2, 1, 3'b000, 3),              3,  32'h00000002};
        tbl[3]  = '{r_t(7'h20, 1, 2, 3'b000, 4),              4,  32'hFFFFFFF8};
        tbl[4]  = '{r_t(7'h00, 1, 2, 3'b010, 5),              5,  32'h00000001};
        tbl[5]  = '{r_t(7'h00, 2, 1, 3'b010, 6),              6,  32'h00000000};
        tbl[6]  = '{r_t(7'h00, 2, 1, 3'b111, 7),              7,  32'h00000005};
        tbl[7]  = '{r_t(7'h00, 2, 1, 3'b110, 8),              8,  32'hFFFFFFFD};
        tbl[8]  = '{i_t(32'hF0, 2, 3'b111, 9, 7'b0010011),    9,  32'h000000F0};
        tbl[9]  = '{i_t(-2048, 1, 3'b110, 10, 7'b0010011),    10, 32'hFFFFF805};
        tbl[10] = '{i_t(-2, 2, 3'b010, 11, 7'b0010011),       11, 32'h00000001};
        tbl[11] = '{addi(0, 1, 7),                            0,  32'h00000000};
        tbl[12] = '{addi(12, 2, 3),                           12, 32'h00000000};
        tbl[13] = '{addi(13, 2, -2048),                       13, 32'hFFFFF7FD};

        // Reset state with ready tied high
        clr_img();
        force_rdy = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("req during reset", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset first req", {31'b0, mem_req}, 32'd1);
        chk("reset first addr", mem_addr, 32'h100);
        chk("reset pc", pc, 32'h100);
        chk("reset we", {31'b0, mem_we}, 32'd0);
        chk("reset wdata", mem_wdata, 32'd0);
        chk("reset retire", {31'b0, retire}, 32'd0);
        chk("reset halted", {31'b0, halted}, 32'd0);
        force_rdy = 1'b0;

        // Reset aborting a pending load
        clr_img();
        img[64] = i_t(8, 0, 3'b010, 6, 7'b0000011);
        lat_cfg = 8;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_req && !mem_we && mem_addr == 32'h8) begin found = 1'b1; break; end
        end
        chk("memread reached", {31'b0, found}, 32'd1);
        rst = 1'b0;
        #1 chk("abort req drop", {31'b0, mem_req}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort pc", pc, 32'h100);
        chk("abort fetch addr", mem_addr, 32'h100);

        // Vector table of ALU instructions, zero-wait memory
        clr_img();
        lat_cfg = 0;
        for (int k = 0; k < 14; k++) img[64 + k] = tbl[k].instr;
        do_reset();
        t0 = cyc;
        tprev = cyc;
        for (int k = 0; k < 14; k++) begin
            wait_retire($sformatf("tbl%0d retire", k));
            chk($sformatf("tbl%0d spacing", k), cyc - tprev, (k == 0) ? 32'd3 : 32'd4);
            tprev = cyc;
            @(posedge clk);
            #1 chk($sformatf("tbl%0d x%0d", k, tbl[k].rd), dut.r_rf[tbl[k].rd], tbl[k].exp);
        end
        // Illegal all-zero word follows: halt right after DECODE
        @(negedge clk);
        @(negedge clk);
        chk("halt not in decode", {31'b0, halted}, 32'd0);
        @(negedge clk);
        chk("halted", {31'b0, halted}, 32'd1);
        nr0 = nret;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("halt req low", {31'b0, mem_req}, 32'd0);
        end
        chk("halt no retire", nret, nr0);

        // Store then load with three wait states per access
        clr_img();
        img[2]  = 32'hDEADBEEF;
        img[64] = addi(1, 0, 5);
        img[65] = s_t(8, 1, 0);
        img[66] = i_t(8, 0, 3'b010, 6, 7'b0000011);
        lat_cfg = 3;
        do_reset();
        wait_retire("ls addi");
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mem_req && mem_we) begin found = 1'b1; break; end
        end
        chk("sw request seen", {31'b0, found}, 32'd1);
        nw = 0;
        for (int i = 0; i < 10; i++) begin
            chk("sw addr", mem_addr, 32'h8);
            chk("sw wdata", mem_wdata, 32'h5);
            if (mem_ready) break;
            nw++;
            @(negedge clk);
        end
        chk("sw wait cycles", nw, 32'd3);
        chk("sw retire", {31'b0, retire}, 32'd1);
        @(negedge clk);
        t0 = cyc;
        chk("lw fetch addr", mem_addr, 32'h108);
        wait_retire("lw retire");
        chk("lw latency", cyc - t0, 32'd10);
        @(posedge clk);
        #1;
        chk("lw x6", dut.r_rf[6], 32'h5);
        chk("sw mem[8]", mem[2], 32'h5);
        lat_cfg = 0;

        // Branches
        run_beq("beq taken", b_t(16, 1, 1), 32'h30);
        run_beq("beq not taken", b_t(16, 2, 1), 32'h24);

        // jal with link, then jal x0, then illegal halt
        clr_img();
        img[64] = j_t(32'h40 - 32'h100, 0);
        img[16] = j_t(-8, 7);
        img[14] = j_t(12, 0);
        do_reset();
        wait_retire("jal prelude");
        wait_retire("jal x7");
        @(posedge clk);
        #1 chk("jal x7 link", dut.r_rf[7], 32'h44);
        @(negedge clk);
        chk("jal target", mem_addr, 32'h38);
        wait_retire("jal x0 retire");
        @(posedge clk);
        #1;
        chk("jal x0 discard", dut.r_rf[0], 32'h0);
        chk("jal x0 keeps x7", dut.r_rf[7], 32'h44);
        @(negedge clk);
        chk("jal x0 target", mem_addr, 32'h44);
        wait_halt("jal halt");

        // Illegal funct7 on an R-type opcode
        clr_img();
        img[64] = r_t(7'b0000001, 2, 1, 3'b000, 3);
        do_reset();
        wait_halt("illegal funct halt");
        chk("illegal funct no retire", nret, 32'd0);

        // Random programs against the instruction-level model
        rand_lat = 1'b1;
        for (int t = 0; t < 20; t++) begin
            clr_img();
            for (int k = 0; k < 16; k++) begin
                img[128 + k] = $urandom;
                md[k] = img[128 + k];
            end
            for (int r = 0; r < 8; r++) mr[r] = 32'h0;
            for (int k = 0; k < 12; k++) begin
                prog[k].kind = $urandom_range(0, 10);
                prog[k].rd   = $urandom_range(0, 7);
                prog[k].rs1  = $urandom_range(0, 7);
                prog[k].rs2  = $urandom_range(0, 7);
                if (prog[k].kind >= 9) prog[k].imm = 32'h200 + 4 * int'($urandom_range(0, 15));
                else                   prog[k].imm = int'($urandom_range(0, 4095)) - 2048;
                img[64 + k] = enc(prog[k]);
                a = mr[prog[k].rs1];
                b = (prog[k].kind <= 3) ? 32'(prog[k].imm) : mr[prog[k].rs2];
                case (prog[k].kind)
                    5:       res = a - b;
                    1, 6:    res = a & b;
                    2, 7:    res = a | b;
                    3, 8:    res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    10:      res = md[(prog[k].imm - 32'h200) / 4];
                    default: res = a + b;
                endcase
                if (prog[k].kind == 9)      md[(prog[k].imm - 32'h200) / 4] = mr[prog[k].rs2];
                else if (prog[k].rd != 0)   mr[prog[k].rd] = res;
            end
            do_reset();
            wait_halt($sformatf("rnd%0d halt", t));
            chk($sformatf("rnd%0d retires", t), nret, 32'd12);
            for (int r = 1; r < 8; r++)
                chk($sformatf("rnd%0d x%0d", t, r), dut.r_rf[r], mr[r]);
            for (int k = 0; k < 16; k++)
                chk($sformatf("rnd%0d mem%0d", t, k), mem[128 + k], md[k]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
